// File: rtl/conv1_wb_pkg.sv
// rtl/conv1_wb_pkg.sv - shared constants and types for the conv1 write-back stage
//
// Purpose: default layer geometry, derived beat count / address width,
//          total pixel count and the write-back FSM state type.
// Ports:   none (package).
package conv1_wb_pkg;

  localparam int DEF_DSP_NO = 64;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_LANES  = 4;
  localparam int DEF_OUT_W  = 128;
  localparam int DEF_OUT_H  = 128;

  localparam int BEATS     = DEF_DSP_NO / DEF_LANES;
  localparam int PIX_TOTAL = DEF_OUT_W * DEF_OUT_H;
  localparam int ADDR_W    = $clog2(PIX_TOTAL * BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } wb_state_t;

endpackage

// File: rtl/conv1_wb_beat_mux.sv
// rtl/conv1_wb_beat_mux.sv - selects one LANES-wide slice of the active vector
//
// Purpose: combinational slice select; beat b drives channels
//          b*LANES .. b*LANES+LANES-1 with the lowest channel in the LSBs.
// Ports:
//   buf_data  in   active channel vector
//   beat      in   beat index within the pixel
//   wr_data   out  packed LANES*WIDTH slice
module conv1_wb_beat_mux #(
  parameter int DSP_NO = 64,
  parameter int WIDTH  = 16,
  parameter int LANES  = 4,
  parameter int BEATS  = DSP_NO / LANES,
  parameter int BW     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic [WIDTH-1:0]       buf_data [0:DSP_NO-1],
  input  logic [BW-1:0]          beat,
  output logic [LANES*WIDTH-1:0] wr_data
);

  // Unrolled compare per beat keeps every array index a constant.
  always_comb begin
    wr_data = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat == BW'(b)) begin
        for (int l = 0; l < LANES; l++) begin
          wr_data[l*WIDTH +: WIDTH] = buf_data[b*LANES + l];
        end
      end
    end
  end

endmodule

// File: rtl/conv1_wb.sv
// rtl/conv1_wb.sv - conv1 output write-back: vector capture, beat drain, end-of-layer detect
//
// Purpose: latches each DSP_NO-channel output vector and writes it to the
//          feature-map RAM as BEATS consecutive LANES-wide words, pixel-major.
//          Optional feature macro: CONV1_WB_DBUF_EN adds a pending vector
//          register so a new vector can be accepted while draining.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   ofm_valid  in   one-cycle pulse, ofm holds a new pixel vector
//   ofm        in   channel vector
//   in_ready   out  a vector presented now will be accepted
//   wr_en      out  RAM write strobe
//   wr_addr    out  RAM word address (pix*BEATS + beat)
//   wr_data    out  LANES channels of the current beat
//   wb_done    out  sticky, all pixels written
//   ovf_err    out  sticky, a vector was dropped
module conv1_wb
  import conv1_wb_pkg::*;
#(
  parameter int DSP_NO = DEF_DSP_NO,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LANES  = DEF_LANES,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int OUT_H  = DEF_OUT_H,
  localparam int NBEATS = DSP_NO / LANES,
  localparam int NPIX   = OUT_W * OUT_H,
  localparam int AW     = $clog2(NPIX * NBEATS),
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1,
  localparam int PW     = $clog2(NPIX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ofm_valid,
  input  logic [WIDTH-1:0]       ofm [0:DSP_NO-1],
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [AW-1:0]          wr_addr,
  output logic [LANES*WIDTH-1:0] wr_data,
  output logic                   wb_done,
  output logic                   ovf_err
);

  wb_state_t        state, state_nxt;
  logic [BW-1:0]    beat;
  logic [PW-1:0]    pix_cnt;
  logic [WIDTH-1:0] act_buf [0:DSP_NO-1];
  logic             accept, last_beat, pix_last, have_next;

`ifdef CONV1_WB_DBUF_EN
  logic [WIDTH-1:0] pend_buf [0:DSP_NO-1];
  logic             pend_valid;
`endif

  assign accept    = ofm_valid & in_ready;
  assign last_beat = (state == DRAIN) && (beat == BW'(NBEATS - 1));
  assign pix_last  = (pix_cnt == PW'(NPIX - 1));

`ifdef CONV1_WB_DBUF_EN
  // A vector arriving on the last beat is taken straight into the active buffer.
  assign have_next = pend_valid | accept;
`else
  assign have_next = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = DRAIN;
      DRAIN: begin
        if (last_beat) begin
          if (pix_last)       state_nxt = DONE;
          else if (have_next) state_nxt = DRAIN;
          else                state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs, derived from registered state only
  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    wb_done  = 1'b0;
    case (state)
      IDLE:  in_ready = 1'b1;
      DRAIN: begin
        wr_en = 1'b1;
`ifdef CONV1_WB_DBUF_EN
        in_ready = ~pend_valid;
`endif
      end
      DONE:    wb_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: buffers, beat and pixel counters, overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat    <= '0;
      pix_cnt <= '0;
      ovf_err <= 1'b0;
      act_buf <= '{default: '0};
`ifdef CONV1_WB_DBUF_EN
      pend_buf   <= '{default: '0};
      pend_valid <= 1'b0;
`endif
    end else begin
      if (ofm_valid && !in_ready) ovf_err <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            act_buf <= ofm;
            beat    <= '0;
          end
        end
        DRAIN: begin
          if (last_beat) begin
            beat    <= '0;
            pix_cnt <= pix_cnt + 1'b1;
`ifdef CONV1_WB_DBUF_EN
            if (pend_valid) begin
              act_buf    <= pend_buf;
              pend_valid <= 1'b0;
            end else if (accept) begin
              act_buf <= ofm;
            end
`endif
          end else begin
            beat <= beat + 1'b1;
`ifdef CONV1_WB_DBUF_EN
            if (accept) begin
              pend_buf   <= ofm;
              pend_valid <= 1'b1;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Linear address: wraps to zero only once pix_cnt reaches NPIX, when wr_en is low.
  assign wr_addr = AW'(int'(pix_cnt) * NBEATS + int'(beat));

  conv1_wb_beat_mux #(
    .DSP_NO (DSP_NO),
    .WIDTH  (WIDTH),
    .LANES  (LANES),
    .BEATS  (NBEATS),
    .BW     (BW)
  ) u_beat_mux (
    .buf_data (act_buf),
    .beat     (beat),
    .wr_data  (wr_data)
  );

endmodule
